// File: rtl/cmp_arbiter.sv
// cmp_arbiter
//
// Two requesters share a single unsigned WIDTH-bit magnitude comparator.
// A round-robin arbiter accepts one operand pair at a time. The pair is
// compared on the next cycle, and the result is held on rsp_* until the
// consumer takes it. One result is produced at most every three cycles.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req0_valid   requester 0 offers an operand pair
//   req0_ready   requester 0 pair accepted this cycle
//   req0_a/b     requester 0 operands (unsigned, WIDTH bits)
//   req1_valid   requester 1 offers an operand pair
//   req1_ready   requester 1 pair accepted this cycle
//   req1_a/b     requester 1 operands (unsigned, WIDTH bits)
//   rsp_valid    result available
//   rsp_ready    consumer accepts the result
//   rsp_id       requester that owns the result
//   rsp_greater  a >  b for the owning request
//   rsp_lesser   a <  b for the owning request
//   rsp_equal    a == b for the owning request
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_greater,
    output logic             rsp_lesser,
    output logic             rsp_equal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             id_q, id_d;
    logic             rspValid_q, rspValid_d;
    logic             rspId_q, rspId_d;
    logic             rspGreater_q, rspGreater_d;
    logic             rspLesser_q, rspLesser_d;
    logic             rspEqual_q, rspEqual_d;

    logic             grant0;
    logic             grant1;
    logic             winner;
    logic             aGtB;
    logic             aEqB;
    logic             aLtB;

    // The one shared comparator always looks at the latched operands.
    // "Lesser" is derived rather than compared a second time.
    always_comb begin
        aGtB = (opA_q > opB_q);
        aEqB = (opA_q == opB_q);
        aLtB = !aGtB && !aEqB;
    end

    // Next-state logic. prio_q names the requester that wins when both are
    // valid. It flips away from whoever was just accepted.
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        id_d         = id_q;
        rspValid_d   = rspValid_q;
        rspId_d      = rspId_q;
        rspGreater_d = rspGreater_q;
        rspLesser_d  = rspLesser_q;
        rspEqual_d   = rspEqual_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        winner       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        winner = prio_q;
                    end else begin
                        winner = req1_valid;
                    end
                    grant0  = !winner;
                    grant1  = winner;
                    opA_d   = winner ? req1_a : req0_a;
                    opB_d   = winner ? req1_b : req0_b;
                    id_d    = winner;
                    prio_d  = !winner;
                    state_d = CMP;
                end
            end
            CMP: begin
                rspValid_d   = 1'b1;
                rspId_d      = id_q;
                rspGreater_d = aGtB;
                rspLesser_d  = aLtB;
                rspEqual_d   = aEqB;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValid_d   = 1'b0;
                    rspGreater_d = 1'b0;
                    rspLesser_d  = 1'b0;
                    rspEqual_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset discards any in-flight work and restores the
    // pointer so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            opA_q        <= '0;
            opB_q        <= '0;
            id_q         <= 1'b0;
            rspValid_q   <= 1'b0;
            rspId_q      <= 1'b0;
            rspGreater_q <= 1'b0;
            rspLesser_q  <= 1'b0;
            rspEqual_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            id_q         <= id_d;
            rspValid_q   <= rspValid_d;
            rspId_q      <= rspId_d;
            rspGreater_q <= rspGreater_d;
            rspLesser_q  <= rspLesser_d;
            rspEqual_q   <= rspEqual_d;
        end
    end

    // The grants are combinational from IDLE. They are masked while reset
    // is held, so nothing appears accepted during reset.
    assign req0_ready  = grant0 && !rst;
    assign req1_ready  = grant1 && !rst;
    assign rsp_valid   = rspValid_q;
    assign rsp_id      = rspId_q;
    assign rsp_greater = rspGreater_q;
    assign rsp_lesser  = rspLesser_q;
    assign rsp_equal   = rspEqual_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter.
//
// A reference model of the arbiter runs on every falling clock edge. It
// predicts which requester is granted and pushes the expected result into
// a scoreboard queue at that point. When the response appears, the model
// checks it against the front of the queue on every cycle it is held. It
// pops the entry on the handshake.
module tb_cmp_arbiter;

    localparam int WIDTH = 32;

    typedef struct {
        logic id;
        logic gt;
        logic lt;
        logic eq;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic             rsp_greater;
    logic             rsp_lesser;
    logic             rsp_equal;

    int   checks;
    int   passes;
    int   grantCount;
    int   age;
    logic busy;
    logic prio;
    exp_t sb[$];

    cmp_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_greater (rsp_greater),
        .rsp_lesser  (rsp_lesser),
        .rsp_equal   (rsp_equal)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison is made here. The task counts it and reports any
    // difference between observed and expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model and scoreboard. It samples on the falling edge, away
    // from the rising edge where the DUT updates.
    always @(negedge clk) begin
        logic v0, v1, win;
        exp_t e;
        if (rst) begin
            checkOutput("rstReady0", req0_ready, 0);
            checkOutput("rstReady1", req1_ready, 0);
            checkOutput("rstRspValid", rsp_valid, 0);
            checkOutput("rstRspFlags", {rsp_id, rsp_greater, rsp_lesser, rsp_equal}, 0);
            busy = 1'b0;
            age  = 0;
            prio = 1'b0;
            sb.delete();
        end else if (!busy) begin
            checkOutput("idleRspValid", rsp_valid, 0);
            v0 = req0_valid;
            v1 = req1_valid;
            if (v0 || v1) begin
                win = (v0 && v1) ? prio : v1;
                checkOutput("grant0", req0_ready, (win == 1'b0));
                checkOutput("grant1", req1_ready, (win == 1'b1));
                e.id = win;
                if (win) begin
                    e.gt = req1_a > req1_b; e.lt = req1_a < req1_b; e.eq = req1_a == req1_b;
                end else begin
                    e.gt = req0_a > req0_b; e.lt = req0_a < req0_b; e.eq = req0_a == req0_b;
                end
                sb.push_back(e);
                busy = 1'b1;
                age  = 0;
                prio = !win;
                grantCount++;
            end else begin
                checkOutput("noReqReady", {req0_ready, req1_ready}, 0);
            end
        end else begin
            age++;
            checkOutput("busyReady", {req0_ready, req1_ready}, 0);
            checkOutput("rspValidTiming", rsp_valid, (age >= 2));
            if (age >= 2 && sb.size() > 0) begin
                e = sb[0];
                checkOutput("rspId", rsp_id, e.id);
                checkOutput("rspFlags", {rsp_greater, rsp_lesser, rsp_equal}, {e.gt, e.lt, e.eq});
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    busy = 1'b0;
                end
            end
        end
    end

    // Drives all requester inputs and rsp_ready just after a rising edge.
    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic rr);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    // Waits until the model has counted a given total of grants. Running
    // out of cycles is counted as a failed comparison.
    task automatic waitGrants(input int target);
        int n;
        n = 0;
        while (grantCount < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("grantTimeout", (grantCount >= target), 1);
    endtask

    // Waits for the model to return to idle with an empty scoreboard.
    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy || sb.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleTimeout", (!busy && sb.size() == 0), 1);
    endtask

    // Sends one pair from a single requester and waits for its result.
    task automatic sendOne(input logic which, input logic [31:0] a, input logic [31:0] b);
        int target;
        target = grantCount + 1;
        applyStimulus(!which, a, b, which, a, b, 1'b1);
        waitGrants(target);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();
    endtask

    initial begin
        int target;
        checks = 0; passes = 0; grantCount = 0; age = 0;
        busy = 1'b0; prio = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 0; req0_b = 0;
        req1_valid = 1'b1; req1_a = 0; req1_b = 0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single requester 5 vs 3");
        sendOne(1'b0, 32'h0000_0005, 32'h0000_0003);

        $display("[TB] reset-then-tie, equal vs lesser");
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1, 1'b1);
        rst = 1'b0;
        target = grantCount + 2;
        waitGrants(target);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();

        $display("[TB] continuous contention, operands changing each cycle");
        target = grantCount + 6;
        while (grantCount < target) begin
            applyStimulus(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b1);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();

        $display("[TB] consumer stall with noisy requesters");
        target = grantCount + 1;
        applyStimulus(1'b0, 0, 0, 1'b1, 32'h1234, 32'h1234, 1'b0);
        waitGrants(target);
        for (int i = 0; i < 7; i++) begin
            applyStimulus($urandom_range(0, 1), $urandom, $urandom,
                          $urandom_range(0, 1), $urandom, $urandom, 1'b0);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();

        $display("[TB] reset during compare");
        sendOne(1'b0, 32'h1, 32'h2);
        target = grantCount + 1;
        applyStimulus(1'b1, 32'h9, 32'h9, 1'b0, 0, 0, 1'b1);
        waitGrants(target);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        target = grantCount + 2;
        applyStimulus(1'b1, 32'h3, 32'h4, 1'b1, 32'h4, 32'h3, 1'b1);
        waitGrants(target);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();

        $display("[TB] unsigned top bit");
        sendOne(1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
        sendOne(1'b1, 32'h7FFF_FFFF, 32'h8000_0000);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] x;
            x = $urandom;
            applyStimulus($urandom_range(0, 1), x, ($urandom_range(0, 3) == 0) ? x : $urandom,
                          $urandom_range(0, 1), $urandom, x, $urandom_range(0, 1));
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
